// File: rtl/vga_img_pkg.sv
// Shared definitions for the VGA image subsystem.
//   ADDR_W / DATA_W : image ROM address and word widths
//   img_code_e      : 4-bit image codes placed in the upper ROM address bits
//   PORT_*          : requester indices used as read-return tags
package vga_img_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int IMG_W  = 4;
    localparam int ROW_W  = 5;

    typedef enum logic [IMG_W-1:0] {
        IMG_NONE   = 4'd0,
        CALENDARIO = 4'd1,
        CRONO      = 4'd2,
        HORA       = 4'd3,
        AVATAR     = 4'd4
    } img_code_e;

    localparam logic [1:0] PORT_DISP = 2'd0;
    localparam logic [1:0] PORT_AUX1 = 2'd1;
    localparam logic [1:0] PORT_AUX2 = 2'd2;

    // ROM address = {image code, row select}
    function automatic logic [ADDR_W-1:0] make_rom_addr(input img_code_e code,
                                                        input logic [ROW_W-1:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/linea_latencia_rom.sv
// ROM_LAT-deep valid/tag shift register that tracks reads in flight through
// the image ROM. A synchronous clear drops every outstanding read.
//   reloj     : clock
//   clr       : synchronous clear (active high)
//   in_valid  : a read was issued to the ROM
//   in_tag    : port index owning that read
//   out_valid : read data is on the ROM output this cycle
//   out_tag   : port index owning the ROM output
module linea_latencia_rom
    import vga_img_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic       reloj,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [1:0] in_tag,
    output logic       out_valid,
    output logic [1:0] out_tag
);

    logic [ROM_LAT-1:0]       vld_q;
    logic [ROM_LAT-1:0][1:0]  tag_q;

    always_ff @(posedge reloj) begin
        if (clr) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[ROM_LAT-1];
    assign out_tag   = tag_q[ROM_LAT-1];

endmodule

// File: rtl/arbitro_rom_imagenes.sv
// Arbiter sharing the synchronous image ROM between the pixel path (port 0)
// and two auxiliary readers (ports 1, 2). Port 0 has strict priority; ports 1
// and 2 share a round-robin pointer. The winning address is registered to the
// ROM and the read is tracked so that data returns tagged with its port.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, each auxiliary port has a saturating wait counter; a port
//   that has waited WAIT_MAX cycles beats port 0 for one cycle, and
//   disp_stall flags every cycle in which port 0 was denied.
//
// Ports:
//   reloj, resetM        : clock, synchronous active-high reset
//   req0/addr0           : pixel-path request and address
//   req1/addr1           : auxiliary port 1 request and address
//   req2/addr2           : auxiliary port 2 request and address
//   gnt                  : one-hot grant, combinational
//   rom_addr             : registered ROM address
//   rom_data             : ROM read data
//   rdata/rvalid/rtag    : returned data, valid flag and owning port
//   disp_stall           : port 0 denied this cycle (guard feature only)
module arbitro_rom_imagenes
    import vga_img_pkg::*;
#(
    parameter int ADDR_W   = vga_img_pkg::ADDR_W,
    parameter int DATA_W   = vga_img_pkg::DATA_W,
    parameter int ROM_LAT  = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic              reloj,
    input  logic              resetM,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [1:0]        rtag,
    output logic              disp_stall
);

    // 0: port 1 preferred, 1: port 2 preferred
    logic       ptr_aux2;
    logic [2:0] gnt_c;
    logic [1:0] win_tag;
    logic       iss_valid;
    logic [1:0] iss_tag;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    logic [3:0] wait1;
    logic [3:0] wait2;
    logic       urg1;
    logic       urg2;

    assign urg1 = req1 && (wait1 >= WAIT_LIM);
    assign urg2 = req2 && (wait2 >= WAIT_LIM);

    // Counters clear on grant or when the request drops, saturate at 15.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            wait1 <= '0;
            wait2 <= '0;
        end else begin
            if (!req1 || gnt_c[1])    wait1 <= '0;
            else if (wait1 != 4'hF)   wait1 <= wait1 + 4'd1;
            if (!req2 || gnt_c[2])    wait2 <= '0;
            else if (wait2 != 4'hF)   wait2 <= wait2 + 4'd1;
        end
    end

    assign disp_stall = req0 && !gnt_c[0] && !resetM;
`else
    logic unused_cfg;
    assign unused_cfg = ^WAIT_MAX;
    assign disp_stall = 1'b0;
`endif

    always_comb begin
        gnt_c = 3'b000;
        if (!resetM) begin
            if (req0)
                gnt_c = 3'b001;
            else if (req1 || req2)
                gnt_c = (req2 && (!req1 || ptr_aux2)) ? 3'b100 : 3'b010;
`ifdef ARB_STARVE_GUARD_EN
            if (urg1 || urg2)
                gnt_c = (urg2 && (!urg1 || ptr_aux2)) ? 3'b100 : 3'b010;
`endif
        end
    end

    assign gnt = gnt_c;

    always_comb begin
        win_tag = PORT_DISP;
        if (gnt_c[1]) win_tag = PORT_AUX1;
        if (gnt_c[2]) win_tag = PORT_AUX2;
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            ptr_aux2  <= 1'b0;
            rom_addr  <= '0;
            iss_valid <= 1'b0;
            iss_tag   <= PORT_DISP;
        end else begin
            if (gnt_c[1])      ptr_aux2 <= 1'b1;
            else if (gnt_c[2]) ptr_aux2 <= 1'b0;

            // Idle cycles leave the ROM address where it was.
            case (gnt_c)
                3'b001:  rom_addr <= addr0;
                3'b010:  rom_addr <= addr1;
                3'b100:  rom_addr <= addr2;
                default: rom_addr <= rom_addr;
            endcase

            iss_valid <= |gnt_c;
            iss_tag   <= win_tag;
        end
    end

    // The issue stage lines up with rom_addr; the line covers the ROM latency.
    linea_latencia_rom #(
        .ROM_LAT (ROM_LAT)
    ) u_linea (
        .reloj     (reloj),
        .clr       (resetM),
        .in_valid  (iss_valid),
        .in_tag    (iss_tag),
        .out_valid (rvalid),
        .out_tag   (rtag)
    );

    assign rdata = rom_data;

endmodule

// File: tb/tb_arbitro_rom_imagenes.sv
module tb_arbitro_rom_imagenes;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       reloj;
    logic       resetM;
    logic       req0, req1, req2;
    logic [8:0] addr0, addr1, addr2;

    logic [4:1][2:0]  gnt_v;
    logic [4:1][8:0]  rom_addr_v;
    logic [4:1][31:0] rom_data_v;
    logic [4:1][31:0] rdata_v;
    logic [4:1]       rvalid_v;
    logic [4:1][1:0]  rtag_v;
    logic [4:1]       stall_v;

    int n_checks = 0;
    int n_errors = 0;

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    function automatic logic [31:0] rom_fn(input logic [8:0] a);
        return {7'h55, a, ~a, 7'h2A};
    endfunction

    for (genvar k = 1; k <= 4; k++) begin : g_lat
        logic [31:0] rom_pipe [0:k-1];

        always @(posedge reloj) begin
            rom_pipe[0] <= rom_fn(rom_addr_v[k]);
            for (int i = 1; i < k; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
        assign rom_data_v[k] = rom_pipe[k-1];

        arbitro_rom_imagenes #(
            .ROM_LAT  (k),
            .WAIT_MAX (15)
        ) u_dut (
            .reloj      (reloj),
            .resetM     (resetM),
            .req0       (req0),
            .addr0      (addr0),
            .req1       (req1),
            .addr1      (addr1),
            .req2       (req2),
            .addr2      (addr2),
            .gnt        (gnt_v[k]),
            .rom_addr   (rom_addr_v[k]),
            .rom_data   (rom_data_v[k]),
            .rdata      (rdata_v[k]),
            .rvalid     (rvalid_v[k]),
            .rtag       (rtag_v[k]),
            .disp_stall (stall_v[k])
        );
    end

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    initial begin
        logic [2:0]  exp_g;
        logic [1:0]  exp_tag;
        logic [8:0]  exp_addr;
        int          src;

        resetM = 1'b1;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        addr0 = 9'h011; addr1 = 9'h022; addr2 = 9'h033;

        // Reset with every request high
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            for (int k = 1; k <= 4; k++) begin
                chequear("rst_gnt",    32'(gnt_v[k]), 32'h0);
                chequear("rst_rvalid", 32'(rvalid_v[k]), 32'h0);
                chequear("rst_stall",  32'(stall_v[k]), 32'h0);
            end
            chequear("rst_rom_addr", 32'(rom_addr_v[1]), 32'h0);
            chequear("rst_rtag",     32'(rtag_v[1]), 32'h0);
        end

        // Pixel path priority over port 1 (guard build: port 1 wins cycle 16)
        for (int i = 0; i < 24; i++) begin
            tick();
            resetM = 1'b0;
            req0 = 1'b1; addr0 = 9'h060 + 9'(i);
            req1 = 1'b1; addr1 = 9'h080;
            req2 = 1'b0;
            #1;
            exp_g = (GUARD && i == 15) ? 3'b010 : 3'b001;
            chequear("prio_gnt",   32'(gnt_v[1]), 32'(exp_g));
            chequear("prio_stall", 32'(stall_v[1]), 32'(GUARD && i == 15));
            if (i >= 1) begin
                exp_addr = (GUARD && i - 1 == 15) ? 9'h080 : 9'h060 + 9'(i - 1);
                chequear("prio_rom_addr", 32'(rom_addr_v[1]), 32'(exp_addr));
            end
            if (i < 2) begin
                chequear("prio_first_rvalid", 32'(rvalid_v[1]), 32'h0);
            end else begin
                src = i - 2;
                exp_addr = (GUARD && src == 15) ? 9'h080 : 9'h060 + 9'(src);
                exp_tag  = (GUARD && src == 15) ? 2'd1 : 2'd0;
                chequear("prio_rvalid", 32'(rvalid_v[1]), 32'h1);
                chequear("prio_rtag",   32'(rtag_v[1]), 32'(exp_tag));
                chequear("prio_rdata",  rdata_v[1], rom_fn(exp_addr));
            end
        end

        // Reset pulse, then round-robin between ports 1 and 2
        tick();
        resetM = 1'b1; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        #1;
        chequear("rst2_gnt", 32'(gnt_v[1]), 32'h0);

        for (int j = 0; j < 6; j++) begin
            tick();
            resetM = 1'b0;
            req0 = 1'b0;
            req1 = 1'b1; addr1 = 9'h0A1;
            req2 = 1'b1; addr2 = 9'h0B2;
            #1;
            exp_g = (j % 2 == 0) ? 3'b010 : 3'b100;
            chequear("rr_gnt", 32'(gnt_v[1]), 32'(exp_g));
            if (j == 0) begin
                chequear("rr_rvalid_after_rst", 32'(rvalid_v[1]), 32'h0);
                chequear("rr_rom_addr_rst",     32'(rom_addr_v[1]), 32'h0);
            end else begin
                exp_addr = ((j - 1) % 2 == 0) ? 9'h0A1 : 9'h0B2;
                chequear("rr_rom_addr", 32'(rom_addr_v[1]), 32'(exp_addr));
            end
            if (j >= 2) begin
                exp_tag  = ((j - 2) % 2 == 0) ? 2'd1 : 2'd2;
                exp_addr = ((j - 2) % 2 == 0) ? 9'h0A1 : 9'h0B2;
                chequear("rr_rvalid", 32'(rvalid_v[1]), 32'h1);
                chequear("rr_rtag",   32'(rtag_v[1]), 32'(exp_tag));
                chequear("rr_rdata",  rdata_v[1], rom_fn(exp_addr));
            end
        end

        // Idle: no grant, address held, pipeline drains
        for (int d = 0; d < 3; d++) begin
            tick();
            req1 = 1'b0; req2 = 1'b0;
            #1;
            chequear("idle_gnt",      32'(gnt_v[1]), 32'h0);
            chequear("idle_rom_addr", 32'(rom_addr_v[1]), 32'h0B2);
            chequear("idle_rvalid",   32'(rvalid_v[1]), 32'(d < 2));
            if (d < 2) chequear("idle_rtag", 32'(rtag_v[1]), 32'(d == 0 ? 1 : 2));
        end

        // Pointer untouched by idle cycles: port 1 preferred again
        tick();
        req1 = 1'b1; req2 = 1'b1;
        #1;
        chequear("ptr_hold_gnt", 32'(gnt_v[1]), 32'h2);

        for (int d = 0; d < 6; d++) begin
            tick();
            req1 = 1'b0; req2 = 1'b0;
            #1;
            chequear("drain_gnt", 32'(gnt_v[1]), 32'h0);
        end

        // Latency sweep: single port 2 read at 0x09F on every ROM_LAT
        tick();
        req2 = 1'b1; addr2 = 9'h09F;
        #1;
        for (int k = 1; k <= 4; k++) chequear("lat_gnt", 32'(gnt_v[k]), 32'h4);
        for (int c = 1; c <= 6; c++) begin
            tick();
            req2 = 1'b0;
            #1;
            for (int k = 1; k <= 4; k++) begin
                chequear("lat_rvalid", 32'(rvalid_v[k]), 32'(c == k + 1));
                if (c == k + 1) begin
                    chequear("lat_rtag",  32'(rtag_v[k]), 32'h2);
                    chequear("lat_rdata", rdata_v[k], rom_fn(9'h09F));
                end
            end
        end

        // Reset one cycle after a port 2 grant: that read never returns
        tick();
        req2 = 1'b1; addr2 = 9'h0B7;
        #1;
        chequear("mid_gnt", 32'(gnt_v[3]), 32'h4);
        tick();
        req2 = 1'b0; req0 = 1'b1; resetM = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            chequear("mid_rst_gnt",   32'(gnt_v[k]), 32'h0);
            chequear("mid_rst_stall", 32'(stall_v[k]), 32'h0);
        end
        tick();
        resetM = 1'b0; req0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int k = 1; k <= 4; k++) chequear("mid_no_rvalid", 32'(rvalid_v[k]), 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arbitro_rom_imagenes.md
Name: arbitro_rom_imagenes

Overview:
- Shares the single synchronous image ROM (9-bit address: 4-bit image code + 5-bit row select) between three requesters.
- Port 0 is the pixel path address generator, which drives a request every active-video cycle. Ports 1 and 2 are auxiliary readers (icon preview, self-test).
- Arbitrates, registers the ROM address, tracks the ROM read latency and returns data tagged with the winning port.
- Sits between the image-position logic and the image ROM in the VGA subsystem.

Parameters:
- ADDR_W, 9, ROM address width.
- DATA_W, 32, ROM word width (one image row).
- ROM_LAT, 1, ROM read latency in cycles from registered address to valid data (1..4).
- WAIT_MAX, 15, auxiliary wait limit in cycles; used only with the optional feature.

Ports:
- reloj  in  1  system clock; all logic on the rising edge.
- resetM  in  1  synchronous, active-high reset.
- req0  in  1  pixel-path request.
- addr0  in  ADDR_W  pixel-path address.
- req1  in  1  auxiliary port 1 request.
- addr1  in  ADDR_W  auxiliary port 1 address.
- req2  in  1  auxiliary port 2 request.
- addr2  in  ADDR_W  auxiliary port 2 address.
- gnt  out  3  one-hot grant, combinational this cycle; at most one bit set.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM read data.
- rdata  out  DATA_W  returned data (rom_data forwarded).
- rvalid  out  1  rdata valid this cycle.
- rtag  out  2  port index owning rdata (0, 1, 2).
- disp_stall  out  1  pulse: req0 was denied this cycle (optional feature only).

Behaviour:
- Reset (synchronous, resetM=1 at an edge):
  - rom_addr=0, rvalid=0, rtag=0, disp_stall=0.
  - Round-robin pointer set to port 1.
  - Wait counters cleared.
  - Latency pipeline flushed; reads in flight are discarded and never return.
  - gnt=0 while resetM=1.
- Priority: req0 always wins (strict), except when the optional feature overrides it.
- Auxiliary arbitration: ports 1 and 2 share round-robin. The pointer names the preferred port.
  - After an auxiliary grant, the pointer moves to the other auxiliary port.
  - The pointer is unchanged on port-0 grants and on idle cycles.
- Handshake:
  - A requester holds reqN high and addrN stable until it sees gnt[N]=1.
  - The grant consumes that request. A requester re-asserts in the next cycle for another read.
  - Port 0 is exempt from the hold rule; it may change address every cycle.
- Pipeline:
  - Grant in cycle t: rom_addr <= addrN at the edge ending t.
  - Tag/valid shift register of depth ROM_LAT gives rvalid=1, rtag=N, rdata=rom_data in cycle t+1+ROM_LAT.
  - One grant per cycle gives full throughput: back-to-back grants produce back-to-back rvalid.
- No request: rom_addr holds its last value; a 0 enters the valid pipeline.
- Simultaneous req1 and req2 with no req0: the pointer's port wins.
- Reset asserted mid-read: the outstanding rvalid never appears, and rvalid=0 in the cycle after the reset edge.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Enabled:
  - A 4-bit saturating wait counter per auxiliary port increments each cycle its req is high and it is not granted.
  - The counter clears when the port is granted or when its req is low.
  - When a counter reaches WAIT_MAX, that port beats req0 for one cycle. If both ports reach the limit, the pointer breaks the tie.
  - disp_stall=1 in any cycle where req0=1 and gnt[0]=0.
- Disabled:
  - Strict priority; auxiliary ports can starve.
  - disp_stall is tied to 0 and no counters are built.

Decomposition:
- Shared package vga_img_pkg holds:
  - ADDR_W and DATA_W.
  - Image codes: CALENDARIO=1, CRONO=2, HORA=3, AVATAR=4.
  - Port index constants PORT_DISP=0, PORT_AUX1=1, PORT_AUX2=2.
- One sub-module: linea_latencia_rom, a ROM_LAT-deep valid/tag shift register with synchronous clear. The arbiter core stays in the top.

Test Plan:
- Reset behaviour: resetM=1 for 2 cycles with all req=1 -> gnt=000, rvalid=0. After release with ROM_LAT=1, the first rvalid appears 2 cycles after the first grant, with rtag=0.
- Strict priority: req0 continuous with addr0=0x060..0x07F, req1=1 addr1=0x080 -> gnt=001 every cycle. rdata sequence matches ROM[0x060..] in order; port 1 is never granted (feature off).
- Round-robin: req1=req2=1 held, req0=0, new requests after each grant -> grants alternate 010,100,010 starting with port 1. rtag alternates 1,2,1.
- Starvation guard (feature on, WAIT_MAX=15): req0 and req1 continuous -> port 1 is granted in cycle 16 after release. disp_stall=1 for exactly that cycle, and the rtag=1 return arrives ROM_LAT+1 cycles later.
- Reset mid-operation (ROM_LAT=3): grant port 2, then assert resetM 1 cycle later -> no rvalid with rtag=2 ever appears.
- Latency sweep over ROM_LAT=1..4 with a single req2 at addr 0x09F -> rvalid exactly ROM_LAT+1 cycles after gnt=100, with rdata=ROM[0x09F].
